// File: rtl/retire_rat.sv
// Retirement register alias table.
// Applies committed register writes to the architectural map and sends each
// displaced physical register to a small release FIFO. On a flush it replays
// the whole committed map, one entry per cycle.
module retire_rat #(
    parameter  int unsigned NUM_ARCH_REGS   = 32,
    parameter  int unsigned NUM_PHYS_REGS   = 64,
    parameter  int unsigned FREE_FIFO_DEPTH = 8,
    localparam int unsigned LOG_ARCH        = $clog2(NUM_ARCH_REGS),
    localparam int unsigned LOG_PHYS        = $clog2(NUM_PHYS_REGS)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Commit_valid_IN,
    input  logic                RegUpdate_IN,
    input  logic [LOG_ARCH-1:0] Arch_reg_IN,
    input  logic [LOG_PHYS-1:0] Phys_reg_IN,
    output logic                Commit_stall_OUT,
    output logic                Free_valid_OUT,
    output logic [LOG_PHYS-1:0] Free_reg_OUT,
    input  logic                Free_ready_IN,
    input  logic                Flush_IN,
    output logic                Busy_OUT,
    output logic                Copy_valid_OUT,
    output logic [LOG_ARCH-1:0] Copy_arch_OUT,
    output logic [LOG_PHYS-1:0] Copy_phys_OUT,
    input  logic [LOG_ARCH-1:0] Lookup_arch_IN,
    output logic [LOG_PHYS-1:0] Lookup_phys_OUT,
    output logic [31:0]         Commit_count_OUT
);

    localparam int unsigned LOG_FIFO = $clog2(FREE_FIFO_DEPTH);
    localparam int unsigned FIFO_CW  = LOG_FIFO + 1;

    localparam logic [FIFO_CW-1:0]  FIFO_FULL = FIFO_CW'(FREE_FIFO_DEPTH);
    localparam logic [LOG_ARCH-1:0] IDX_LAST  = LOG_ARCH'(NUM_ARCH_REGS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_COPY = 1'b1;

    logic [LOG_PHYS-1:0] r_map [NUM_ARCH_REGS];
    logic [LOG_PHYS-1:0] r_fifo [FREE_FIFO_DEPTH];
    logic [LOG_FIFO-1:0] r_head;
    logic [LOG_FIFO-1:0] r_tail;
    logic [FIFO_CW-1:0]  r_count;
    logic [0:0]          r_state;
    logic [LOG_ARCH-1:0] r_idx;
    logic [31:0]         r_commit_count;

    logic [0:0]          w_state_nxt;
    logic [LOG_ARCH-1:0] w_idx_nxt;
    logic                w_stall;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_map_we;
    logic [LOG_PHYS-1:0] w_push_data;

    // Commit handshake; stall depends only on registered state so a
    // same-cycle pop at full never frees room for a push.
    always_comb begin
        w_stall     = (r_count == FIFO_FULL) || (r_state == ST_COPY);
        w_accept    = Commit_valid_IN && !w_stall;
        w_push      = w_accept && RegUpdate_IN;
        w_map_we    = w_push && (Arch_reg_IN != '0);
        w_pop       = (r_count != '0) && Free_ready_IN;
        // $zero is never remapped, so the incoming register is released directly
        w_push_data = (Arch_reg_IN == '0) ? Phys_reg_IN : r_map[Arch_reg_IN];
    end

    // Architectural map: identity after reset, updated by accepted commits.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                r_map[i] <= LOG_PHYS'(i);
            end
        end else if (w_map_we) begin
            r_map[Arch_reg_IN] <= Phys_reg_IN;
        end
    end

    // Release FIFO storage; contents are only meaningful below r_count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo[r_tail] <= w_push_data;
        end
    end

    // Release FIFO pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + LOG_FIFO'(1);
            end
            if (w_pop) begin
                r_head <= r_head + LOG_FIFO'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FIFO_CW'(1);
                2'b01:   r_count <= r_count - FIFO_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Accepted-commit counter, wraps naturally at 32 bits.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_commit_count <= '0;
        end else if (w_accept) begin
            r_commit_count <= r_commit_count + 32'd1;
        end
    end

    // Replay FSM state register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Replay FSM next state; a flush in COPY restarts from index 0.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (Flush_IN) begin
                    w_state_nxt = ST_COPY;
                    w_idx_nxt   = '0;
                end
            end
            ST_COPY: begin
                if (Flush_IN) begin
                    w_idx_nxt = '0;
                end else if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + LOG_ARCH'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        Commit_stall_OUT = w_stall;
        Free_valid_OUT   = (r_count != '0);
        Free_reg_OUT     = r_fifo[r_head];
        Busy_OUT         = (r_state == ST_COPY);
        Copy_valid_OUT   = (r_state == ST_COPY);
        Copy_arch_OUT    = '0;
        Copy_phys_OUT    = '0;
        if (r_state == ST_COPY) begin
            Copy_arch_OUT = r_idx;
            Copy_phys_OUT = r_map[r_idx];
        end
        Lookup_phys_OUT  = r_map[Lookup_arch_IN];
        Commit_count_OUT = r_commit_count;
    end

endmodule

// File: tb/tb_retire_rat.sv
// Randomized scoreboard bench for retire_rat against a queue-based model.
module tb_retire_rat;

    logic        CLK;
    logic        RESET;
    logic        Commit_valid_IN;
    logic        RegUpdate_IN;
    logic [4:0]  Arch_reg_IN;
    logic [5:0]  Phys_reg_IN;
    logic        Commit_stall_OUT;
    logic        Free_valid_OUT;
    logic [5:0]  Free_reg_OUT;
    logic        Free_ready_IN;
    logic        Flush_IN;
    logic        Busy_OUT;
    logic        Copy_valid_OUT;
    logic [4:0]  Copy_arch_OUT;
    logic [5:0]  Copy_phys_OUT;
    logic [4:0]  Lookup_arch_IN;
    logic [5:0]  Lookup_phys_OUT;
    logic [31:0] Commit_count_OUT;

    retire_rat dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .Commit_valid_IN  (Commit_valid_IN),
        .RegUpdate_IN     (RegUpdate_IN),
        .Arch_reg_IN      (Arch_reg_IN),
        .Phys_reg_IN      (Phys_reg_IN),
        .Commit_stall_OUT (Commit_stall_OUT),
        .Free_valid_OUT   (Free_valid_OUT),
        .Free_reg_OUT     (Free_reg_OUT),
        .Free_ready_IN    (Free_ready_IN),
        .Flush_IN         (Flush_IN),
        .Busy_OUT         (Busy_OUT),
        .Copy_valid_OUT   (Copy_valid_OUT),
        .Copy_arch_OUT    (Copy_arch_OUT),
        .Copy_phys_OUT    (Copy_phys_OUT),
        .Lookup_arch_IN   (Lookup_arch_IN),
        .Lookup_phys_OUT  (Lookup_phys_OUT),
        .Commit_count_OUT (Commit_count_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state
    int          m_map [32];
    int          m_cnt;
    int          m_left;
    int unsigned m_commits;
    bit          m_init;
    int          exp_free [$];
    logic [10:0] exp_copy [$];

    int n_cmp;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_map[i] = i;
        m_cnt     = 0;
        m_left    = 0;
        m_commits = 0;
        exp_free.delete();
        exp_copy.delete();
        m_init    = 1'b1;
    endtask

    // One clock of stimulus; the model advances at the edge the DUT samples.
    task automatic cycle(input logic rst_n, input logic cv, input logic ru,
                         input logic [4:0] arch, input logic [5:0] phys,
                         input logic fr, input logic fl, input logic [4:0] la);
        logic acc;
        logic pop;
        @(negedge CLK);
        RESET           = rst_n;
        Commit_valid_IN = cv;
        RegUpdate_IN    = ru;
        Arch_reg_IN     = arch;
        Phys_reg_IN     = phys;
        Free_ready_IN   = fr;
        Flush_IN        = fl;
        Lookup_arch_IN  = la;
        acc = rst_n && cv && !((m_cnt == 8) || (m_left > 0));
        pop = rst_n && (m_cnt != 0) && fr;
        @(posedge CLK);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (acc) begin
                m_commits++;
                if (ru) begin
                    exp_free.push_back((arch == 5'd0) ? int'(phys) : m_map[arch]);
                    if (arch != 5'd0) m_map[arch] = int'(phys);
                    m_cnt++;
                end
            end
            if (pop) m_cnt--;
            if (m_left > 0) m_left--;
            if (fl) begin
                exp_copy.delete();
                for (int i = 0; i < 32; i++) exp_copy.push_back({5'(i), 6'(m_map[i])});
                m_left = 32;
            end
        end
    endtask

    task automatic idle(input int n, input logic fr);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, fr, 1'b0, 5'(i));
    endtask

    // Monitor: compares DUT outputs mid-cycle and drains the scoreboards on handshakes.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge CLK);
            #1;
            if (m_init) begin
                chk("stall", 32'(Commit_stall_OUT), 32'((m_cnt == 8) || (m_left > 0)));
                chk("free_valid", 32'(Free_valid_OUT), 32'(m_cnt != 0));
                chk("busy", 32'(Busy_OUT), 32'(m_left > 0));
                chk("copy_valid", 32'(Copy_valid_OUT), 32'(m_left > 0));
                chk("commit_count", Commit_count_OUT, m_commits);
                chk("lookup", 32'(Lookup_phys_OUT), 32'(m_map[Lookup_arch_IN]));
                if (Free_valid_OUT && Free_ready_IN) begin
                    if (exp_free.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL free_pop: got release of %0d expected none", Free_reg_OUT);
                    end else begin
                        chk("free_reg", 32'(Free_reg_OUT), 32'(exp_free.pop_front()));
                    end
                end
                if (Copy_valid_OUT) begin
                    if (exp_copy.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL copy_entry: got arch %0d expected no entry", Copy_arch_OUT);
                    end else begin
                        e = exp_copy.pop_front();
                        chk("copy_arch", 32'(Copy_arch_OUT), 32'(e[10:6]));
                        chk("copy_phys", 32'(Copy_phys_OUT), 32'(e[5:0]));
                    end
                end else begin
                    chk("copy_arch_idle", 32'(Copy_arch_OUT), 32'd0);
                    chk("copy_phys_idle", 32'(Copy_phys_OUT), 32'd0);
                end
            end
        end
    end

    initial begin
        int fr_mod;
        n_cmp  = 0;
        n_fail = 0;
        m_init = 1'b0;
        m_cnt  = 0;
        m_left = 0;
        RESET = 1'b0; Commit_valid_IN = 1'b0; RegUpdate_IN = 1'b0; Arch_reg_IN = '0;
        Phys_reg_IN = '0; Free_ready_IN = 1'b0; Flush_IN = 1'b0; Lookup_arch_IN = '0;

        // Reset and identity map
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 5'd5);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 5'd5);
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0, 5'd5);

        // Single commit, then release it
        cycle(1'b1, 1'b1, 1'b1, 5'd3, 6'd40, 1'b0, 1'b0, 5'd3);
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 5'd3);
        idle(2, 1'b1);

        // $zero write and a non-register commit
        cycle(1'b1, 1'b1, 1'b1, 5'd0, 6'd50, 1'b0, 1'b0, 5'd0);
        cycle(1'b1, 1'b1, 1'b0, 5'd9, 6'd9, 1'b0, 1'b0, 5'd0);
        idle(3, 1'b1);

        // Fill the FIFO, hold a 9th commit, pulse ready
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b1, 1'b1, 5'(i + 1), 6'(20 + i), 1'b0, 1'b0, 5'(i + 1));
        cycle(1'b1, 1'b1, 1'b1, 5'd12, 6'd60, 1'b0, 1'b0, 5'd12);
        cycle(1'b1, 1'b1, 1'b1, 5'd12, 6'd60, 1'b0, 1'b0, 5'd12);
        cycle(1'b1, 1'b1, 1'b1, 5'd12, 6'd60, 1'b1, 1'b0, 5'd12);
        cycle(1'b1, 1'b1, 1'b1, 5'd12, 6'd60, 1'b0, 1'b0, 5'd12);
        idle(12, 1'b1);

        // Commit plus flush in the same cycle; commits during replay are stalled
        cycle(1'b1, 1'b1, 1'b1, 5'd7, 6'd33, 1'b1, 1'b1, 5'd7);
        for (int i = 0; i < 34; i++)
            cycle(1'b1, 1'b1, 1'b1, 5'd4, 6'd44, 1'b1, 1'b0, 5'd4);
        idle(3, 1'b1);

        // Replay restarted at idx 10, then aborted by reset
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 5'd0);
        idle(10, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b1, 5'd0);
        idle(5, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 1'b0, 5'd7);
        idle(4, 1'b1);

        // Randomized traffic with phases of varying free-list backpressure
        for (int i = 0; i < 2000; i++) begin
            fr_mod = (i / 150) % 3;
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)),
                  6'($urandom_range(0, 63)),
                  (fr_mod == 0) ? ($urandom_range(0, 7) == 0) :
                  (fr_mod == 1) ? ($urandom_range(0, 1) == 0) :
                                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 59) == 0),
                  5'($urandom_range(0, 31)));
        end

        // Drain everything and confirm nothing expected was left behind
        idle(45, 1'b1);
        chk("free_leftover", 32'(exp_free.size()), 32'd0);
        chk("copy_leftover", 32'(exp_copy.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/retire_rat.md
Name: retire_rat

Overview:
- Retirement register alias table. Sits directly downstream of the reorder buffer and consumes its commit stream: the commit-valid strobe, RegUpdate, the architectural register and the physical register.
- On each committed register write it updates the architectural-to-physical mapping. It pushes the displaced physical register into a small release FIFO that drains to the free list.
- On a flush it replays the whole committed map, one entry per cycle, so the front-end RAT can be restored.

Parameters:
- NUM_ARCH_REGS, 32, architectural register count; LOG_ARCH = $clog2(NUM_ARCH_REGS).
- NUM_PHYS_REGS, 64, physical register count; LOG_PHYS = $clog2(NUM_PHYS_REGS).
- FREE_FIFO_DEPTH, 8, entries in the release FIFO; must be a power of two.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset; synchronous, active-low.
- Commit_valid_IN  in  1  ROB presents a committing instruction.
- RegUpdate_IN  in  1  the committing instruction writes a register.
- Arch_reg_IN  in  LOG_ARCH  destination architectural register.
- Phys_reg_IN  in  LOG_PHYS  physical register now holding the committed value.
- Commit_stall_OUT  out  1  commit not accepted this cycle; ROB must hold its outputs.
- Free_valid_OUT  out  1  release FIFO non-empty.
- Free_reg_OUT  out  LOG_PHYS  physical register being released (FIFO head).
- Free_ready_IN  in  1  free list accepts the head entry.
- Flush_IN  in  1  start a map replay.
- Busy_OUT  out  1  replay in progress.
- Copy_valid_OUT  out  1  replay entry valid.
- Copy_arch_OUT  out  LOG_ARCH  replay architectural index.
- Copy_phys_OUT  out  LOG_PHYS  mapping for Copy_arch_OUT.
- Lookup_arch_IN  in  LOG_ARCH  debug/recovery read address.
- Lookup_phys_OUT  out  LOG_PHYS  current map entry; combinational read, no write bypass.
- Commit_count_OUT  out  32  count of accepted commits; wraps modulo 2^32.

Behaviour:
- Reset, applied at the CLK edge while RESET=0:
  - map[i] = i for all i.
  - FIFO head, tail and count = 0.
  - State = IDLE, replay index = 0, Commit_count_OUT = 0.
  - Resulting outputs: Free_valid_OUT=0, Copy_valid_OUT=0, Busy_OUT=0, Commit_stall_OUT=0.
  - Reset during a replay aborts it.
- Commit_stall_OUT = (count == FREE_FIFO_DEPTH) OR (state == COPY). It is combinational from registered state only.
- A commit is accepted when Commit_valid_IN=1 and Commit_stall_OUT=0.
  - Every accepted commit increments Commit_count_OUT, with or without RegUpdate_IN.
- Accepted commit with RegUpdate_IN=1, Arch_reg_IN != 0:
  - Push the old map[Arch_reg_IN] into the FIFO.
  - Write map[Arch_reg_IN] <= Phys_reg_IN.
  - Both take effect at the same edge.
- Accepted commit with RegUpdate_IN=1, Arch_reg_IN == 0: the map is unchanged and Phys_reg_IN itself is pushed. Register $zero is never remapped.
- Accepted commit with RegUpdate_IN=0: no map change, no push.
- Release FIFO:
  - Free_valid_OUT = (count != 0); Free_reg_OUT = fifo[head].
  - Pop when Free_valid_OUT AND Free_ready_IN.
  - Push and pop in the same cycle leave count unchanged.
  - Head and tail wrap modulo FREE_FIFO_DEPTH.
  - A pop at full does not permit a same-cycle push, because stall is evaluated from the registered count.
- Replay FSM, states IDLE and COPY:
  - IDLE, Flush_IN=1: go to COPY with idx=0. Any commit accepted in that same cycle is written to the map first.
  - In COPY: Copy_valid_OUT=1, Busy_OUT=1, Copy_arch_OUT=idx, Copy_phys_OUT=map[idx]. Each cycle idx increments.
  - In COPY with idx == NUM_ARCH_REGS-1: return to IDLE and set idx=0.
  - Latency: Flush_IN high at edge N gives replay entries on cycles N+1 through N+NUM_ARCH_REGS.
  - Flush_IN=1 while in COPY restarts the replay at idx=0.
  - The FIFO is neither cleared nor frozen by a flush; draining continues during a replay.
- Outside COPY, Copy_arch_OUT and Copy_phys_OUT drive 0.

Test Plan:
- Reset check: RESET low for 2 cycles, then release; Lookup_arch_IN=5 -> Lookup_phys_OUT=5; Free_valid_OUT=0, Busy_OUT=0, Commit_count_OUT=0.
- Single commit: commit Arch=3, Phys=40, RegUpdate=1 -> next cycle map[3]=40, Free_valid_OUT=1, Free_reg_OUT=3. With Free_ready_IN=1 -> Free_valid_OUT=0 one cycle later.
- $zero and non-register commits: Arch=0, Phys=50, RegUpdate=1 -> map[0] stays 0, Free_reg_OUT=50. RegUpdate=0 commit -> no push, Commit_count_OUT still increments.
- FIFO full: Free_ready_IN=0, 8 consecutive updating commits -> Commit_stall_OUT=1 and a held 9th commit not applied. Pulse Free_ready_IN -> stall drops and the 9th commit is accepted the following cycle.
- Replay: commit Arch=7, Phys=33 in the same cycle as Flush_IN -> Busy_OUT high 32 cycles; the cycle with Copy_arch_OUT=7 shows Copy_phys_OUT=33. Commits presented during the replay are stalled.
- Interrupted replay: Flush_IN reasserted at idx=10 -> next cycle Copy_arch_OUT=0. RESET low mid-replay -> Busy_OUT=0 and the map is back to identity.
